// File: rtl/key_schedule.sv
// Round-key generator for a toy 8-bit nibble cipher: emits the cipher key followed by
// NUM_ROUNDS derived round keys over a valid/ready handshake.
module key_schedule #(
  parameter int unsigned NUM_ROUNDS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0][1:0] key_in,
  input  logic            rk_ready,
  output logic            rk_valid,
  output logic [3:0][1:0] rk_out,
  output logic [3:0]      rk_index,
  output logic            busy,
  output logic            done
);

  typedef enum logic {StIdle, StEmit} state_e;

  localparam logic [3:0] LastIndex = 4'(NUM_ROUNDS);

  state_e     state_q;
  logic       last_round;
  logic [3:0] nxt_index;
  logic [7:0] nxt_key;

  function automatic logic [1:0] sbox(input logic [1:0] c);
    logic [1:0] s;
    case (c)
      2'd0:    s = 2'd2;
      2'd1:    s = 2'd0;
      2'd2:    s = 2'd3;
      default: s = 2'd1;
    endcase
    return s;
  endfunction

  // Round constant cycles 01,10,11 starting at round 1; zero outside 1..8.
  function automatic logic [1:0] rcon(input logic [3:0] r);
    logic [1:0] c;
    case (r)
      4'd1, 4'd4, 4'd7: c = 2'b01;
      4'd2, 4'd5, 4'd8: c = 2'b10;
      4'd3, 4'd6:       c = 2'b11;
      default:          c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] next_key(input logic [7:0] key, input logic [3:0] r);
    logic [3:0] w0, w1, rot, sub, w0n, w1n;
    w0  = key[7:4];
    w1  = key[3:0];
    rot = {w1[1:0], w1[3:2]};
    sub = {sbox(rot[3:2]), sbox(rot[1:0])};
    w0n = w0 ^ sub ^ {rcon(r), 2'b00};
    w1n = w0n ^ w1;
    return {w0n, w1n};
  endfunction

  always_comb begin
    last_round = (rk_index == LastIndex);
    nxt_index  = rk_index + 4'd1;
    nxt_key    = next_key(rk_out, nxt_index);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_index <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StEmit;
            rk_out   <= key_in;
            rk_index <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StEmit: begin
          // rk_valid is always high here, so rk_ready alone marks a transfer.
          if (rk_ready) begin
            if (last_round) begin
              state_q  <= StIdle;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk_out   <= nxt_key;
              rk_index <= nxt_index;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule: randomized and directed stimulus against a
// cell-level reference model; a second instance covers the single-round configuration.
module tb_key_schedule;

  localparam int unsigned NR = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, rk_ready;
  logic [7:0] key_in;
  logic       rk_valid, busy, done;
  logic [7:0] rk_out;
  logic [3:0] rk_index;

  logic       start1, ready1;
  logic [7:0] key1;
  logic       v1, busy1, done1;
  logic [7:0] out1;
  logic [3:0] idx1;

  always #5 clk = ~clk;

  key_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_index (rk_index),
    .busy     (busy),
    .done     (done)
  );

  key_schedule #(.NUM_ROUNDS(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .key_in   (key1),
    .rk_ready (ready1),
    .rk_valid (v1),
    .rk_out   (out1),
    .rk_index (idx1),
    .busy     (busy1),
    .done     (done1)
  );

  typedef struct packed {
    logic [7:0] key;
    logic [3:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   sb_idle = 1'b1;
  bit   exp_done = 1'b0;
  bit   mon_empty;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next round key from the cell-level description: words of two cells, rotate, S-box, Rcon.
  function automatic logic [7:0] ref_next(input logic [7:0] k, input int r);
    int sb[4];
    int rc[8];
    int c[4];
    int n[4];
    sb = '{2, 0, 3, 1};
    rc = '{1, 2, 3, 1, 2, 3, 1, 2};
    for (int i = 0; i < 4; i++) c[i] = int'((k >> (2 * i)) & 8'd3);
    n[3] = c[3] ^ sb[c[0]] ^ rc[r - 1];
    n[2] = c[2] ^ sb[c[1]];
    n[1] = n[3] ^ c[1];
    n[0] = n[2] ^ c[0];
    return 8'((n[3] << 6) | (n[2] << 4) | (n[1] << 2) | n[0]);
  endfunction

  task automatic push_expansion(input logic [7:0] k);
    exp_t       e;
    logic [7:0] key;
    key = k;
    for (int r = 0; r <= int'(NR); r++) begin
      e.key = key;
      e.idx = 4'(r);
      q.push_back(e);
      if (r < int'(NR)) key = ref_next(key, r + 1);
    end
  endtask

  task automatic step(input bit s, input logic [7:0] k, input bit rdy, input bit rn);
    start    = s;
    key_in   = k;
    rk_ready = rdy;
    rst_n    = rn;
    @(posedge clk);
    if (rn && s && sb_idle) push_expansion(k);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    check("drain_empty", q.size(), 0);
  endtask

  // Monitor: sb_idle records whether the DUT sits in IDLE before the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_empty = (q.size() == 0);
      check("rk_valid", rk_valid, !mon_empty);
      check("busy", busy, !mon_empty);
      check("done", done, exp_done);
      exp_done = 1'b0;
      sb_idle  = mon_empty;
      if (!mon_empty) begin
        check("rk_out", rk_out, q[0].key);
        check("rk_index", rk_index, q[0].idx);
        if (rk_ready) begin
          if (q[0].idx == 4'(NR)) exp_done = 1'b1;
          void'(q.pop_front());
        end
      end
      if (!rst_n) begin
        q.delete();
        exp_done = 1'b0;
        sb_idle  = 1'b1;
      end
    end
  end

  initial begin
    start1 = 1'b0;
    key1   = 8'h00;
    ready1 = 1'b0;

    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    check("reset_rk_out", rk_out, 8'h00);
    check("reset_rk_index", rk_index, 4'd0);

    // Full expansion of 0x1F, then a start during the done cycle.
    step(1'b1, 8'h1F, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h3C, 1'b1, 1'b1);
    drain();

    // Backpressure at index 1.
    step(1'b1, 8'h1F, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    drain();

    // Start with a different key while busy must be ignored; reset at index 2.
    step(1'b1, 8'h1F, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("midreset_rk_out", rk_out, 8'h00);
    check("midreset_rk_index", rk_index, 4'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) != 0);
    end
    drain();

    // Single-round instance: exactly two transfers, then the done pulse.
    start1 = 1'b1;
    key1   = 8'h1F;
    ready1 = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    start1 = 1'b0;
    key1   = 8'hFF;
    @(negedge clk);
    check("nr1_valid0", v1, 1'b1);
    check("nr1_key0", out1, 8'h1F);
    check("nr1_idx0", idx1, 4'd0);
    check("nr1_busy0", busy1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("nr1_valid1", v1, 1'b1);
    check("nr1_key1", out1, ref_next(8'h1F, 1));
    check("nr1_idx1", idx1, 4'd1);
    check("nr1_done_early", done1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("nr1_valid_end", v1, 1'b0);
    check("nr1_busy_end", busy1, 1'b0);
    check("nr1_done", done1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("nr1_done_pulse", done1, 1'b0);
    check("nr1_idle", v1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameter: NUM_ROUNDS, default 4, number of round keys produced after the cipher key; legal range 1..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  [3:0][1:0]  cipher key, 4 cells of 2 bits; cell 3 = bits [7:6].
REQ-006 rk_ready  input  1  downstream AddRoundKey stage accepts rk_out this cycle.
REQ-007 rk_valid  output  1  rk_out/rk_index hold a valid round key.
REQ-008 rk_out  output  [3:0][1:0]  current round key, same cell layout as key_in.
REQ-009 rk_index  output  4  round number of rk_out, 0..NUM_ROUNDS.
REQ-010 busy  output  1  high in EMIT state.
REQ-011 done  output  1  one-cycle pulse after final key accepted.

Function
REQ-012 States: IDLE, EMIT; all outputs registered.
REQ-013 IDLE + start=1 -> latch key_in as round key 0, rk_index=0, go EMIT; rk_valid=1 on the following cycle (1-cycle latency).
REQ-014 IDLE + start=0 -> stay; rk_valid=0, busy=0.
REQ-015 Handshake: transfer iff rk_valid && rk_ready on a rising edge.
REQ-016 While rk_valid=1 and rk_ready=0, rk_out and rk_index remain stable.
REQ-017 Transfer with rk_index<NUM_ROUNDS -> next cycle rk_out = next round key, rk_index+1, rk_valid stays 1 (back-to-back, one key per cycle when rk_ready held high).
REQ-018 Transfer with rk_index==NUM_ROUNDS -> go IDLE, rk_valid=0, done=1 for exactly one cycle.
REQ-019 start while in EMIT ignored; key_in changes in EMIT have no effect.
REQ-020 start in the done-pulse cycle (IDLE) is accepted normally.
REQ-021 Words: W0 = cells {3,2}, W1 = cells {1,0}, each 4 bits, high cell first.
REQ-022 RotNib(W) swaps its two cells; SubNib(W) applies S to each cell; S: 0->2, 1->0, 2->3, 3->1.
REQ-023 Rcon(r) = {c,2'b00}, c for r=1..8: 01,10,11,01,10,11,01,10.
REQ-024 Next key for round r: W0' = W0 ^ SubNib(RotNib(W1)) ^ Rcon(r); W1' = W0' ^ W1; rk = {W0',W1'}.
REQ-025 All arithmetic is bitwise XOR, no carries; widths fixed at 2 bits/cell, 8 bits/key.

Reset
REQ-026 rst_n=0 at a rising edge -> IDLE, rk_valid=0, busy=0, done=0, rk_out=0, rk_index=0, regardless of state.
REQ-027 Reset mid-EMIT aborts the expansion; no done pulse; start required again.
REQ-028 rst_n=0 overrides start and rk_ready in the same cycle.

Verification
REQ-029 key_in=8'b00011111, start pulse, rk_ready=1 -> rk_out sequence 0x1F (idx0), 0x0F (idx1), 0xD2 (idx2), ... on consecutive cycles; done one cycle after idx4 transfer.
REQ-030 Backpressure: rk_ready=0 for 3 cycles at idx1 -> rk_out=0x0F, rk_index=1 stable throughout; advance to 0xD2 after rk_ready=1.
REQ-031 start=1 with key_in=0xFF while busy -> sequence unchanged from REQ-029.
REQ-032 rst_n=0 while rk_index=2 -> next cycle rk_valid=0, busy=0, rk_out=0, rk_index=0, done=0.
REQ-033 NUM_ROUNDS=1, key 0x1F -> exactly two transfers (0x1F, 0x0F), then done pulse, IDLE.
REQ-034 start asserted in done cycle -> new expansion begins, rk_valid=1 next cycle with rk_index=0.
